// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo-pair FIFO feeding an I2S master serialiser.
// Define I2S_TX_MONO_DUP_EN to repeat the left word in the mono right slot.
module i2s_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sck_en,
   input  logic                   ten,
   input  logic                   wen,
   input  logic [DW-1:0]          dinL,
   input  logic [DW-1:0]          dinR,
   input  logic                   stereo,
   input  logic [1:0]             standard,
   input  logic [1:0]             word_size,
   output logic                   sd,
   output logic                   ws,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underrun,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nx;
   logic [2*DW-1:0] mem [DEPTH];
   logic [2*DW-1:0] head;
   logic [AW:0]     wptr, rptr, wptr_nx, rptr_nx, lvl_nx;
   logic            push, pop;
   logic [5:0]      bcnt, bcnt_nx, last;
   logic [1:0]      c_std, c_wsz, std_nx, wsz_nx;
   logic [DW-1:0]   wl, wr, wl_nx, wr_nx;
   logic [6:0]      s_nx;
   logic            lj_q, lj_nx, rj_nx;
   logic            wrap, fstart, go_idle, step;

   // Aligned bit at frame position k; Philips is the left-justified
   // stream delayed by one strobe, so only LJ and RJ are computed here.
   function automatic logic slot_bit(
      input logic [5:0]    k,
      input logic [1:0]    wsz,
      input logic          rj,
      input logic [DW-1:0] l,
      input logic [DW-1:0] r
   );
      logic [6:0]    n, s, kk, idx;
      logic [DW-1:0] w, sh;
      logic          hit;
      n  = (wsz == 2'b00) ? 7'd16 : (wsz == 2'b01) ? 7'd24 : 7'd32;
      s  = (wsz == 2'b00) ? 7'd16 : 7'd32;
      kk = {1'b0, k};
      w  = l;
      if (kk >= s) begin
         kk = kk - s;
         w  = r;
      end
      if (rj) begin
         hit = (kk >= s - n);
         idx = s - 7'd1 - kk;
      end else begin
         hit = (kk < n);
         idx = n - 7'd1 - kk;
      end
      sh = (w >> idx) & DW'(1);
      return hit && (sh != '0);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (fstart)  state_nx = RUN;
         RUN:     if (go_idle) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      last    = (c_wsz == 2'b00) ? 6'd31 : 6'd63;
      wrap    = (state == RUN) && sck_en && (bcnt == last);
      fstart  = ten && (((state == IDLE) && sck_en) || wrap);
      go_idle = wrap && !ten;
      step    = fstart || ((state == RUN) && sck_en);
   end

   // FIFO
   assign head    = mem[rptr[AW-1:0]];
   assign push    = wen && !full;
   assign pop     = fstart && !empty;
   assign wptr_nx = wptr + (AW+1)'(push);
   assign rptr_nx = rptr + (AW+1)'(pop);
   assign lvl_nx  = wptr_nx - rptr_nx;
   assign level   = wptr - rptr;

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= {dinL, dinR};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         wptr     <= wptr_nx;
         rptr     <= rptr_nx;
         full     <= lvl_nx[AW];
         empty    <= (lvl_nx == '0);
         overflow <= wen && full;
      end
   end

   // Serialiser next values; config and words switch only at frame start
   always_comb begin
      std_nx  = fstart ? standard : c_std;
      wsz_nx  = fstart ? word_size : c_wsz;
      bcnt_nx = fstart ? 6'd0 : bcnt + 6'd1;
      wl_nx   = wl;
      wr_nx   = wr;
      if (fstart) begin
         wl_nx = empty ? '0 : head[2*DW-1:DW];
         if (empty)       wr_nx = '0;
         else if (stereo) wr_nx = head[DW-1:0];
`ifdef I2S_TX_MONO_DUP_EN
         else             wr_nx = head[2*DW-1:DW];
`else
         else             wr_nx = '0;
`endif
      end
      s_nx  = (wsz_nx == 2'b00) ? 7'd16 : 7'd32;
      lj_nx = slot_bit(bcnt_nx, wsz_nx, 1'b0, wl_nx, wr_nx);
      rj_nx = slot_bit(bcnt_nx, wsz_nx, 1'b1, wl_nx, wr_nx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt     <= '0;
         c_std    <= '0;
         c_wsz    <= '0;
         wl       <= '0;
         wr       <= '0;
         lj_q     <= 1'b0;
         sd       <= 1'b0;
         ws       <= 1'b1;
         underrun <= 1'b0;
      end else begin
         underrun <= fstart && empty;
         if (go_idle) begin
            bcnt <= '0;
            lj_q <= 1'b0;
            sd   <= 1'b0;
            ws   <= 1'b1;
         end else if (step) begin
            bcnt  <= bcnt_nx;
            c_std <= std_nx;
            c_wsz <= wsz_nx;
            wl    <= wl_nx;
            wr    <= wr_nx;
            lj_q  <= lj_nx;
            ws    <= ({1'b0, bcnt_nx} >= s_nx);
            unique case (1'b1)
               (std_nx == 2'b01): sd <= lj_nx;
               (std_nx == 2'b10): sd <= rj_nx;
               default:           sd <= lj_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed and randomized bench with a frame-level model.
// Define I2S_TX_MONO_DUP_EN here as well when the DUT is built with it.
module tb_i2s_tx_fifo;
   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst, sck_en, ten, wen, stereo;
   logic [DW-1:0] dinL, dinR;
   logic [1:0]    standard, word_size;
   logic          sd, ws, full, empty, underrun, overflow;
   logic [3:0]    level;
   logic [9:0]    obsv;

   int checks = 0;
   int errors = 0;

   logic [63:0] q[$];
   bit          m_run, m_carry, m_sd, m_ws, m_ur, m_ov;
   int          m_k, m_s;
   bit          m_bits[64];

   i2s_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst), .sck_en(sck_en), .ten(ten), .wen(wen),
      .dinL(dinL), .dinR(dinR), .stereo(stereo), .standard(standard),
      .word_size(word_size), .sd(sd), .ws(ws), .full(full),
      .empty(empty), .level(level), .underrun(underrun),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   assign obsv = {sd, ws, full, empty, level, underrun, overflow};

   function automatic logic [9:0] expv();
      return {m_sd, m_ws, q.size() == DEPTH, q.size() == 0,
              4'(q.size()), m_ur, m_ov};
   endfunction

   // Whole-frame bit pattern straight from the alignment rules
   task automatic build_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input logic [1:0] std, input logic [1:0] wsz,
                              input logic st);
      int n;
      logic [DW-1:0] re;
      n   = (wsz == 2'b00) ? 16 : (wsz == 2'b01) ? 24 : 32;
      m_s = (wsz == 2'b00) ? 16 : 32;
      if (st) re = r;
      else begin
`ifdef I2S_TX_MONO_DUP_EN
         re = l;
`else
         re = '0;
`endif
      end
      foreach (m_bits[i]) m_bits[i] = 1'b0;
      case (std)
         2'b01: for (int k = 0; k < n; k++) begin
            m_bits[k]       = l[n-1-k];
            m_bits[m_s + k] = re[n-1-k];
         end
         2'b10: for (int k = m_s - n; k < m_s; k++) begin
            m_bits[k]       = l[m_s-1-k];
            m_bits[m_s + k] = re[m_s-1-k];
         end
         default: begin
            m_bits[0] = m_carry;
            for (int k = 1; k <= n; k++) begin
               m_bits[k] = l[n-k];
               if (m_s + k < 2 * m_s) m_bits[m_s + k] = re[n-k];
            end
         end
      endcase
      m_carry = (n == m_s) ? re[0] : 1'b0;
   endtask

   task automatic model_edge();
      bit fs, gi, was_e, was_f;
      logic [63:0] hd;
      was_e = (q.size() == 0);
      was_f = (q.size() == DEPTH);
      fs = ten && sck_en && (!m_run || m_k == 2 * m_s - 1);
      gi = m_run && sck_en && (m_k == 2 * m_s - 1) && !ten;
      m_ur = fs && was_e;
      m_ov = wen && was_f;
      if (fs) begin
         hd = was_e ? 64'd0 : q.pop_front();
         build_frame(hd[63:32], hd[31:0], standard, word_size, stereo);
      end
      if (wen && !was_f) q.push_back({dinL, dinR});
      if (fs) begin
         m_run = 1'b1;
         m_k   = 0;
      end else if (gi) begin
         m_run   = 1'b0;
         m_carry = 1'b0;
      end else if (m_run && sck_en) m_k++;
      m_sd = m_run ? m_bits[m_k] : 1'b0;
      m_ws = m_run ? (m_k >= m_s) : 1'b1;
   endtask

   task automatic model_reset();
      q.delete();
      m_run = 0; m_carry = 0; m_sd = 0; m_ws = 1; m_ur = 0; m_ov = 0;
      m_k = 0; m_s = 16;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_out();
      wen = 0; ten = 0; sck_en = 1;
      for (int i = 0; i < 130; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1; sck_en = 0; ten = 0; wen = 0; dinL = 0; dinR = 0;
      stereo = 1; standard = 0; word_size = 0;
      #3 rst = 0;
      #2;
      model_reset();
      checks++;
      if (obsv !== 10'b0101000000) begin
         errors++;
         $display("FAIL reset got %b want %b", obsv, 10'b0101000000);
      end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      checks++;
      if (obsv !== expv()) begin
         errors++;
         $display("FAIL reset_idle got %b want %b", obsv, expv());
      end
   endtask

   task automatic test_philips16();
      logic [15:0] lv, rv;
      logic [31:0] wv;
      standard = 2'b00; word_size = 2'b00; stereo = 1; sck_en = 1;
      wen = 1; dinL = 32'h0000A5C3; dinR = 32'h00003C5A;
      tick();
      wen = 0; ten = 1; lv = 0; rv = 0; wv = 0;
      for (int i = 0; i <= 32; i++) begin
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL ph16 i=%0d got %b want %b", i, obsv, expv());
         end
         if (i >= 1 && i <= 16) lv = {lv[14:0], sd};
         if (i >= 17)           rv = {rv[14:0], sd};
         if (i < 32)            wv = {wv[30:0], ws};
      end
      checks++;
      if (lv !== 16'hA5C3 || rv !== 16'h3C5A || wv !== 32'h0000FFFF) begin
         errors++;
         $display("FAIL ph16_bits got %h %h %h want a5c3 3c5a 0000ffff",
                  lv, rv, wv);
      end
      idle_out();
      checks++;
      if (obsv !== expv() || ws !== 1'b1 || sd !== 1'b0) begin
         errors++;
         $display("FAIL ph16_idle got %b want %b", obsv, expv());
      end
   endtask

   task automatic test_rj24();
      logic [31:0] lv;
      logic [63:0] wv;
      standard = 2'b10; word_size = 2'b01; stereo = 1; sck_en = 1;
      wen = 1; dinL = 32'h00800001; dinR = $urandom;
      tick();
      wen = 0; ten = 1; lv = 0; wv = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 1) ten = 0;
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL rj24 i=%0d got %b want %b", i, obsv, expv());
         end
         if (i < 32) lv = {lv[30:0], sd};
         wv = {wv[62:0], ws};
      end
      checks++;
      if (lv !== 32'h00800001 || wv !== 64'h00000000FFFFFFFF) begin
         errors++;
         $display("FAIL rj24_bits got %h %h want 00800001 00000000ffffffff",
                  lv, wv);
      end
      tick();
      checks++;
      if (ws !== 1'b1 || sd !== 1'b0 || obsv !== expv()) begin
         errors++;
         $display("FAIL rj24_idle got %b want %b", obsv, expv());
      end
   endtask

   task automatic test_fill_overflow();
      logic [31:0] pl[9], pr[9];
      logic [31:0] lv, rv;
      standard = 2'b01; word_size = 2'b10; stereo = 1; sck_en = 1; ten = 0;
      for (int i = 0; i < 9; i++) begin
         pl[i] = $urandom; pr[i] = $urandom;
         wen = 1; dinL = pl[i]; dinR = pr[i];
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL fill i=%0d got %b want %b", i, obsv, expv());
         end
         if (i == 7) begin
            checks++;
            if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
               errors++;
               $display("FAIL full8 got f=%b l=%0d o=%b want 1 8 0",
                        full, level, overflow);
            end
         end
         if (i == 8) begin
            checks++;
            if (overflow !== 1'b1 || level !== 4'd8) begin
               errors++;
               $display("FAIL ovf got o=%b l=%0d want 1 8", overflow, level);
            end
         end
      end
      wen = 0;
      tick();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pulse got %b want 0", overflow);
      end
      ten = 1;
      for (int f = 0; f < 8; f++) begin
         lv = 0; rv = 0;
         for (int i = 0; i < 64; i++) begin
            if (f == 7 && i == 1) ten = 0;
            tick();
            checks++;
            if (obsv !== expv()) begin
               errors++;
               $display("FAIL drain f=%0d i=%0d got %b want %b",
                        f, i, obsv, expv());
            end
            if (i < 32) lv = {lv[30:0], sd};
            else        rv = {rv[30:0], sd};
         end
         checks++;
         if (lv !== pl[f] || rv !== pr[f]) begin
            errors++;
            $display("FAIL order f=%0d got %h %h want %h %h",
                     f, lv, rv, pl[f], pr[f]);
         end
      end
      tick();
      checks++;
      if (ws !== 1'b1 || empty !== 1'b1 || obsv !== expv()) begin
         errors++;
         $display("FAIL drain_idle got %b want %b", obsv, expv());
      end
   endtask

   task automatic test_underrun();
      int nur, nsd;
      logic [15:0] lv, rv;
      logic [31:0] l, r;
      standard = 2'b01; word_size = 2'b00; stereo = 1; sck_en = 1;
      wen = 0; ten = 1; nur = 0; nsd = 0;
      for (int i = 0; i < 96; i++) begin
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL ur i=%0d got %b want %b", i, obsv, expv());
         end
         nur += int'(underrun);
         nsd += int'(sd);
      end
      checks++;
      if (nur != 3 || nsd != 0) begin
         errors++;
         $display("FAIL ur_count got %0d %0d want 3 0", nur, nsd);
      end
      l = $urandom; r = $urandom;
      wen = 1; dinL = l; dinR = r;
      tick();
      wen = 0;
      checks++;
      if (underrun !== 1'b1 || level !== 4'd1) begin
         errors++;
         $display("FAIL ur_push got u=%b l=%0d want 1 1", underrun, level);
      end
      for (int i = 0; i < 31; i++) tick();
      lv = 0; rv = 0;
      for (int i = 0; i < 32; i++) begin
         if (i == 1) ten = 0;
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL ur_next i=%0d got %b want %b", i, obsv, expv());
         end
         if (i < 16) lv = {lv[14:0], sd};
         else        rv = {rv[14:0], sd};
      end
      checks++;
      if (lv !== l[15:0] || rv !== r[15:0]) begin
         errors++;
         $display("FAIL ur_late got %h %h want %h %h", lv, rv, l[15:0], r[15:0]);
      end
      tick();
   endtask

   task automatic test_mono32();
      logic [31:0] lv, rv, rexp;
`ifdef I2S_TX_MONO_DUP_EN
      rexp = 32'hFFFFFFFF;
`else
      rexp = 32'h0;
`endif
      standard = 2'b01; word_size = 2'b10; stereo = 0; sck_en = 1;
      wen = 1; dinL = 32'hFFFFFFFF; dinR = $urandom;
      tick();
      wen = 0; ten = 1; lv = 0; rv = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 1) ten = 0;
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL mono i=%0d got %b want %b", i, obsv, expv());
         end
         if (i < 32) lv = {lv[30:0], sd};
         else        rv = {rv[30:0], sd};
      end
      checks++;
      if (lv !== 32'hFFFFFFFF || rv !== rexp) begin
         errors++;
         $display("FAIL mono_bits got %h %h want ffffffff %h", lv, rv, rexp);
      end
      tick();
      stereo = 1;
   endtask

   task automatic test_reset_midframe();
      standard = 2'b00; word_size = 2'b01; stereo = 1; sck_en = 1; ten = 0;
      for (int i = 0; i < 3; i++) begin
         wen = 1; dinL = $urandom; dinR = $urandom;
         tick();
      end
      wen = 0; ten = 1;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (obsv !== expv() || m_k != 7) begin
         errors++;
         $display("FAIL pre_rst got %b want %b", obsv, expv());
      end
      #2 rst = 0;
      #1;
      model_reset();
      checks++;
      if (obsv !== 10'b0101000000) begin
         errors++;
         $display("FAIL rst_mid got %b want %b", obsv, 10'b0101000000);
      end
      ten = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_random();
      int rate;
      standard = 2'($urandom); word_size = 2'($urandom);
      stereo = 1'($urandom); ten = 1; rate = 8;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) rate = (c % 1000 == 0) ? 8 : 150;
         sck_en = 1'($urandom);
         wen    = ($urandom % rate) == 0;
         dinL   = $urandom;
         dinR   = $urandom;
         if ($urandom % 80 == 0) begin
            standard = 2'($urandom); word_size = 2'($urandom);
            stereo = 1'($urandom);
         end
         if ($urandom % 300 == 0) ten = ~ten;
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL rand c=%0d got %b want %b", c, obsv, expv());
         end
      end
      wen = 0; ten = 0; sck_en = 1;
      for (int i = 0; i < 130; i++) begin
         tick();
         checks++;
         if (obsv !== expv()) begin
            errors++;
            $display("FAIL rand_end i=%0d got %b want %b", i, obsv, expv());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_philips16();
      test_rj24();
      test_fill_overflow();
      test_underrun();
      test_mono32();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Transmit-side counterpart of the I2S receive FIFO. It buffers parallel left/right sample pairs and serialises them MSB-first onto sd, and it generates ws as the I2S master. One clock domain; serial bits advance only on the sck_en strobe.

Parameters:
DEPTH, 8, number of stereo-pair entries (power of 2, ≥2)
DW, 32, width of each channel word register

Ports:
clk  in  1  block clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
sck_en  in  1  bit strobe; one serial bit per clk edge with sck_en=1
ten  in  1  transmit enable
wen  in  1  push request
dinL  in  DW  left word, LSB-justified
dinR  in  DW  right word, LSB-justified; ignored when stereo=0
stereo  in  1  1=stereo, 0=mono
standard  in  2  00 Philips, 01 left-justified, 10 right-justified, 11 treated as 00
word_size  in  2  00=16 bit, 01=24 bit, 10/11=32 bit
sd  out  1  serial data
ws  out  1  word select; 0=left slot, 1=right slot
full  out  1  FIFO holds DEPTH pairs
empty  out  1  FIFO holds 0 pairs
level  out  $clog2(DEPTH)+1  occupied entries
underrun  out  1  one-cycle pulse
overflow  out  1  one-cycle pulse

Behaviour:
- Reset (rst=0, async): FIFO pointers cleared; sd=0, ws=1, full=0, empty=1, level=0, underrun=0, overflow=0; serialiser idle. Entry contents are don't-care.
- Push: when wen=1 and full=0 before the edge, {dinL,dinR} is written and level increments. When wen=1 and full=1, the write is dropped and overflow pulses. Pointers are DEPTH-wrapped with an extra wrap bit. full and empty are registered and valid the cycle after the update.
- Data width N: 16 when word_size=00, 24 when 01, 32 otherwise. Slot width S is 16 when word_size=00, otherwise 32. Only din[N-1:0] is transmitted.
- Config latch: standard, word_size and stereo are sampled at frame start. Changes mid-frame take effect at the next frame.
- Bit counter bcnt runs 0..2S-1 and advances only on clk edges with sck_en=1.
- States:
  - IDLE: ws=1, sd=0. Leaves when ten=1 and sck_en=1; that edge is frame start with bcnt=0.
  - RUN: the serialiser transmits frames back-to-back.
  - On the edge where bcnt wraps from 2S-1 to 0: if ten=0, go to IDLE (ws=1, sd=0). Otherwise start a new frame.
  - ten deassertion always completes the current frame.
- Frame start (bcnt=0): ws<=0. If empty=0, pop one pair into the shift registers. If empty=1, load zeros and pulse underrun.
  - A push and a pop in the same cycle are both honoured; level is unchanged.
  - A push into an empty FIFO at the same edge as frame start is not visible to that pop, so underrun fires and the pair is sent next frame.
- ws goes to 1 at the edge that sets bcnt=S, and back to 0 at bcnt=0.
- sd value after the edge that sets bcnt=k, for a left-slot word W (right slot is the same with k offset by S):
  - Left-justified: W[N-1-k] for k<N, else 0.
  - Philips: W[N-k] for 1≤k≤N, else 0. The bit at bcnt=0 carries the previous right word's LSB; it is 0 after IDLE or underrun.
  - Right-justified: W[S-1-k] for S-N≤k<S, else 0. Equals left-justified when N=S.
- Mono (stereo=0): the right slot transmits all zeros.
- Latency: with ten=1, the pair at the FIFO head when a frame starts has its left MSB on sd at bcnt=0 (left-justified) or bcnt=1 (Philips).

Optional Feature:
Macro I2S_TX_MONO_DUP_EN.
- Defined: in mono mode the right slot retransmits the left word using identical alignment rules.
- Undefined: the mono right slot is all zeros.
- Stereo behaviour is unaffected either way.

Test Plan:
- Reset mid-frame: assert rst=0 at bcnt=7 → sd=0, ws=1, empty=1, level=0 immediately, with no clock edge needed.
- Philips 16-bit stereo, sck_en=1 every cycle: push L=0x0000A5C3, R=0x00003C5A → ws low for 16 strobes then high for 16; sd bits 1..16 = 1010010111000011, sd bits 17..32 = 0011110001011010, next frame's bit 0 = 0.
- Right-justified 24-bit: push L=0x00800001 → left slot bits 0..7 = 0, bit 8 = 1, bits 9..30 = 0, bit 31 = 1; ws period is 64 strobes.
- Fill and overflow: DEPTH=8, ten=0, 9 pushes → full=1 and level=8 after push 8; push 9 gives an overflow pulse and the contents are unchanged; enabling ten drains the pairs in order.
- Underrun: ten=1 with empty FIFO → underrun pulses at each frame start and sd stays 0; a push at a frame-start edge is transmitted in the following frame.
- Mono left-justified 32-bit: L=0xFFFFFFFF → left slot all ones; right slot all zeros (macro undefined) or all ones (I2S_TX_MONO_DUP_EN defined).
